// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage.
// Owns the program counter, issues one memory request per PC, and presents
// the fetched word to decode. A redirect that arrives while a fetch is in
// flight lets the request finish, then drops its data and continues at the
// redirect target.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no request outstanding; waiting for Stall to clear
//  REQ   | MemReq high at PC; waiting for MemAck
//  HOLD  | InstrOut/InstrPC presented to decode; waiting for acceptance
module pc_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] PCPlusTwo,
    output logic              MemReq,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemData,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    input  logic              Stall,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [DATA_W-1:0] InstrOut,
    output logic [ADDR_W-1:0] InstrPC
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: PC, presented word, squash flag, deferred target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            instr_out_q <= '0;
            instr_pc_q  <= '0;
            squash_q    <= 1'b0;
            target_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_out_q <= instr_out_d;
            instr_pc_q  <= instr_pc_d;
            squash_q    <= squash_d;
            target_q    <= target_d;
        end
    end

    // Next-state logic; a completed fetch that is redirected or squashed
    // goes straight back to fetching instead of presenting anything
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!Stall) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (MemAck) begin
                    if (Redirect || squash_q) state_d = Stall ? ST_IDLE : ST_REQ;
                    else                      state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Redirect || InstrReady) state_d = Stall ? ST_IDLE : ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; the PC never moves while a request is pending
    always_comb begin
        pc_d        = pc_q;
        instr_out_d = instr_out_q;
        instr_pc_d  = instr_pc_q;
        squash_d    = squash_q;
        target_d    = target_q;
        case (state_q)
            ST_IDLE: begin
                if (Redirect) pc_d = RedirectPC;
            end
            ST_REQ: begin
                if (MemAck) begin
                    squash_d = 1'b0;
                    if (Redirect) begin
                        pc_d = RedirectPC;
                    end else if (squash_q) begin
                        pc_d = target_q;
                    end else begin
                        instr_out_d = MemData;
                        instr_pc_d  = pc_q;
                        pc_d        = PCPlusTwo;
                    end
                end else if (Redirect) begin
                    // Later redirects overwrite the target; the last one wins
                    squash_d = 1'b1;
                    target_d = RedirectPC;
                end
            end
            ST_HOLD: begin
                if (Redirect) pc_d = RedirectPC;
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        MemReq     = (state_q == ST_REQ);
        InstrValid = (state_q == ST_HOLD);
        PC         = pc_q;
        InstrOut   = instr_out_q;
        InstrPC    = instr_pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed table, hand-written corner sequences,
// and a randomized run checked against a stream-level reference model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] PC;
    logic [15:0] PCPlusTwo;
    logic        MemReq;
    logic        MemAck;
    logic [15:0] MemData;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        Stall;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] InstrOut;
    logic [15:0] InstrPC;

    // second instance with RESET_PC = FFFF, zero-latency memory tied off
    logic [15:0] pc2, ipc2, iout2, data2, plus2;
    logic        req2, ack2, valid2;

    int n_chk  = 0;
    int n_fail = 0;

    int          mem_lat  = 0;
    bit          mem_rand = 0;
    int          cnt      = 0;
    int          cur_lat  = 0;
    logic [15:0] req_addr = 16'h0;

    logic [15:0] cap2 [2];
    int          n_cap2 = 0;

    pc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .PCPlusTwo(PCPlusTwo),
        .MemReq(MemReq), .MemAck(MemAck), .MemData(MemData),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .InstrOut(InstrOut), .InstrPC(InstrPC)
    );

    pc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .PC(pc2), .PCPlusTwo(plus2),
        .MemReq(req2), .MemAck(ack2), .MemData(data2),
        .Redirect(1'b0), .RedirectPC(16'h0000), .Stall(1'b0),
        .InstrValid(valid2), .InstrReady(1'b1),
        .InstrOut(iout2), .InstrPC(ipc2)
    );

    assign PCPlusTwo = PC + 16'd1;
    assign plus2     = pc2 + 16'd1;
    assign ack2      = req2;
    assign data2     = pc2 ^ 16'hA5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: answers each request after a chosen latency with addr^A5A5
    always @(negedge clk) begin
        if (!rst_n) begin
            MemAck = 1'b0;
            cnt    = 0;
        end else begin
            if (MemAck) cnt = 0;
            if (MemReq) begin
                if (cnt == 0) begin
                    req_addr = PC;
                    cur_lat  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                end else begin
                    chk("mem_addr_stable", {16'h0, PC}, {16'h0, req_addr});
                end
                if (cnt >= cur_lat) begin
                    MemAck  = 1'b1;
                    MemData = PC ^ 16'hA5A5;
                end else begin
                    MemAck = 1'b0;
                    cnt++;
                end
            end else begin
                MemAck = 1'b0;
                cnt    = 0;
            end
        end
    end

    // Capture the first two words presented by the RESET_PC=FFFF instance
    always @(negedge clk) begin
        if (rst_n && valid2 && n_cap2 < 2) begin
            cap2[n_cap2] = ipc2;
            n_cap2++;
        end
    end

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!InstrValid && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_valid", {31'h0, InstrValid}, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_memreq"}, {31'h0, MemReq}, 32'h0);
        chk({tag, "_valid"},  {31'h0, InstrValid}, 32'h0);
        chk({tag, "_iout"},   {16'h0, InstrOut}, 32'h0);
        chk({tag, "_ipc"},    {16'h0, InstrPC}, 32'h0);
        chk({tag, "_pc"},     {16'h0, PC}, 32'h0);
    endtask

    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_req;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [15:0] exp_ipc;
        logic [15:0] exp_iout;
    } vec_t;

    vec_t vecs [8];

    // stream-level model state for the random run
    logic [15:0] exp_pc;
    logic        p_valid, p_ready, p_redir;
    logic [15:0] p_ipc, p_iout, p_tgt;
    int          presented;
    bit          bad;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 16'hA5A5};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'hA5A5};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0001, 16'hA5A4};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0001, 16'hA5A4};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0002, 16'hA5A7};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0002, 16'hA5A7};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0003, 16'hA5A6};

        rst_n      = 1'b0;
        Stall      = 1'b0;
        InstrReady = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 16'h0000;
        MemData    = 16'h0000;
        MemAck     = 1'b0;
        cap2[0]    = 16'h1234;
        cap2[1]    = 16'h1234;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // steady stream, zero-latency memory, decode always ready
        for (int i = 0; i < 8; i++) begin
            Stall      = vecs[i].stall;
            InstrReady = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_memreq", i), {31'h0, MemReq}, {31'h0, vecs[i].exp_req});
            chk($sformatf("tbl%0d_valid", i),  {31'h0, InstrValid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("tbl%0d_pc", i),     {16'h0, PC}, {16'h0, vecs[i].exp_pc});
            chk($sformatf("tbl%0d_ipc", i),    {16'h0, InstrPC}, {16'h0, vecs[i].exp_ipc});
            chk($sformatf("tbl%0d_iout", i),   {16'h0, InstrOut}, {16'h0, vecs[i].exp_iout});
        end

        // decode back-pressure: word at 3 held for 5 cycles
        InstrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid",  {31'h0, InstrValid}, 32'h1);
            chk("hold_ipc",    {16'h0, InstrPC}, 32'h0003);
            chk("hold_iout",   {16'h0, InstrOut}, 32'hA5A6);
            chk("hold_memreq", {31'h0, MemReq}, 32'h0);
            chk("hold_pc",     {16'h0, PC}, 32'h0004);
        end
        InstrReady = 1'b1;
        @(negedge clk);
        InstrReady = 1'b0;
        wait_valid(20);
        chk("release_ipc",  {16'h0, InstrPC}, 32'h0004);
        chk("release_iout", {16'h0, InstrOut}, {16'h0, 16'h0004 ^ 16'hA5A5});

        // redirect during HOLD
        Redirect   = 1'b1;
        RedirectPC = 16'h0040;
        @(negedge clk);
        Redirect = 1'b0;
        chk("redir_hold_valid",  {31'h0, InstrValid}, 32'h0);
        chk("redir_hold_memreq", {31'h0, MemReq}, 32'h1);
        chk("redir_hold_pc",     {16'h0, PC}, 32'h0040);
        wait_valid(20);
        chk("redir_hold_ipc",  {16'h0, InstrPC}, 32'h0040);
        chk("redir_hold_iout", {16'h0, InstrOut}, {16'h0, 16'h0040 ^ 16'hA5A5});
        mem_lat    = 3;
        InstrReady = 1'b1;

        // redirect while a slow fetch is in flight
        @(negedge clk);
        chk("redir_req_memreq0", {31'h0, MemReq}, 32'h1);
        chk("redir_req_pc0",     {16'h0, PC}, 32'h0041);
        Redirect   = 1'b1;
        RedirectPC = 16'h0100;
        bad = 0;
        for (int k = 0; k < 12 && PC != 16'h0100; k++) begin
            @(negedge clk);
            Redirect = 1'b0;
            if (InstrValid) bad = 1;
        end
        chk("redir_req_no_present", {31'h0, bad}, 32'h0);
        chk("redir_req_pc",         {16'h0, PC}, 32'h0100);
        chk("redir_req_memreq",     {31'h0, MemReq}, 32'h1);
        mem_lat = 0;
        wait_valid(20);
        chk("redir_req_ipc", {16'h0, InstrPC}, 32'h0100);

        // async reset mid-HOLD, then Stall at release
        InstrReady = 1'b0;
        @(negedge clk);
        chk("pre_rst_hold_valid", {31'h0, InstrValid}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_hold");
        Stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 16'h0055;
        @(negedge clk);
        Redirect = 1'b0;
        chk("idle_redir_pc", {16'h0, PC}, 32'h0055);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_idle_memreq", {31'h0, MemReq}, 32'h0);
            chk("stall_idle_valid",  {31'h0, InstrValid}, 32'h0);
        end

        // async reset mid-REQ
        mem_lat = 3;
        Stall   = 1'b0;
        @(negedge clk);
        chk("pre_rst_req_memreq", {31'h0, MemReq}, 32'h1);
        chk("pre_rst_req_pc",     {16'h0, PC}, 32'h0055);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_req");

        // RESET_PC = FFFF instance wraps to 0000
        chk("rstpc_count",  n_cap2, 2);
        chk("rstpc_first",  {16'h0, cap2[0]}, 32'hFFFF);
        chk("rstpc_second", {16'h0, cap2[1]}, 32'h0000);

        // randomized run against the stream model
        mem_rand   = 1;
        InstrReady = 1'b0;
        Redirect   = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_pc    = 16'h0000;
        p_valid   = 1'b0;
        p_ready   = 1'b0;
        p_redir   = 1'b0;
        p_ipc     = 16'h0;
        p_iout    = 16'h0;
        p_tgt     = 16'h0;
        presented = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            chk("rnd_req_and_valid", {31'h0, MemReq & InstrValid}, 32'h0);
            if (p_redir) exp_pc = p_tgt;
            if (p_valid && p_redir) begin
                chk("rnd_redir_drops_valid", {31'h0, InstrValid}, 32'h0);
            end else if (p_valid && !p_ready) begin
                chk("rnd_stall_valid", {31'h0, InstrValid}, 32'h1);
                chk("rnd_stall_ipc",   {16'h0, InstrPC}, {16'h0, p_ipc});
                chk("rnd_stall_iout",  {16'h0, InstrOut}, {16'h0, p_iout});
            end else if (InstrValid) begin
                chk("rnd_ipc",  {16'h0, InstrPC}, {16'h0, exp_pc});
                chk("rnd_iout", {16'h0, InstrOut}, {16'h0, exp_pc ^ 16'hA5A5});
                exp_pc = exp_pc + 16'd1;
                presented++;
            end
            p_valid = InstrValid;
            p_ipc   = InstrPC;
            p_iout  = InstrOut;

            Stall      = ($urandom_range(0, 3) == 0);
            InstrReady = ($urandom_range(0, 2) != 0);
            Redirect   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 1) == 0) RedirectPC = 16'hFFFC + 16'($urandom_range(0, 3));
            else                           RedirectPC = 16'($urandom_range(0, 65535));
            p_redir = Redirect;
            p_tgt   = RedirectPC;
            p_ready = InstrReady;
        end
        chk("rnd_progress", {31'h0, presented > 100}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
